// File: rtl/mips_mem_pkg.sv
// Shared types, widths and the address-error rule for the data-memory responder.
package mips_mem_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BE_W       = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  // Misaligned, or any bit above the RAM's word-index range is set.
  function automatic logic addr_err(input logic [DATA_W-1:0] addr, input int unsigned addr_w);
    logic [DATA_W-1:0] hi;
    hi = addr >> (addr_w + 2);
    return (addr[1:0] != 2'b00) || (hi != '0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed RAM with byte-strobed synchronous write and a registered read port.
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter int unsigned AddrW = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [AddrW-1:0]  addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   wstrb_i,
  input  logic              re_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rdata_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < BE_W; i++) begin
      if (wstrb_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end else if (clr_i) begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts a load/store, waits WAIT_STATES cycles, commits to the
// RAM on entry to RESP and holds a registered response until the processor takes it.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              ref_clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam logic [3:0] WaitInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;

  logic              commit, handshake;
  logic              cur_we, cur_err;
  logic [DATA_W-1:0] cur_addr, cur_wdata;
  logic [BE_W-1:0]   cur_be;
  logic [BE_W-1:0]   ram_wstrb;
  logic              ram_re, ram_clr;

  // With zero wait states the commit happens on the accept edge, before the latch is loaded.
  always_comb begin
    if (state_q == StIdle) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_be    = req_be;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
    end
    cur_err = addr_err(cur_addr, ADDR_W);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    commit      = 1'b0;
    handshake   = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          we_d        = req_we;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          be_d        = req_be;
          req_ready_d = 1'b0;
          if (WAIT_STATES == 0) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
          handshake   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (commit) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = cur_err;
    end
  end

  assign ram_wstrb = (commit && cur_we && !cur_err) ? cur_be : '0;
  assign ram_re    = commit && !cur_we && !cur_err;
  assign ram_clr   = (commit && !ram_re) || handshake;

  always_ff @(posedge ref_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  dmem_array #(
    .AddrW(ADDR_W)
  ) u_array (
    .clk_i  (ref_clk),
    .rst_ni (reset),
    .addr_i (cur_addr[ADDR_W+1:2]),
    .wdata_i(cur_wdata),
    .wstrb_i(ram_wstrb),
    .re_i   (ram_re),
    .clr_i  (ram_clr),
    .rdata_o(rsp_rdata)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the processor's data-memory request interface.
- The processor core initiates load/store requests; this block accepts them, inserts a programmable number of wait states, and commits or reads a word-addressed RAM.
- It returns a response under a valid/ready handshake.
- Sits beside the processor core in the top level; its RAM stands in for the data memory during simulation and synthesis.

Parameters:
- ADDR_W, 8, word-index width; RAM depth = 2**ADDR_W 32-bit words
- WAIT_STATES, 2, idle cycles between request accept and response valid (0..15)

Ports:
- ref_clk  input  1  single clock, rising-edge
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- req_valid  input  1  processor request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- req_be  input  4  store byte enables; bit i covers wdata[8i+7:8i]
- rsp_valid  output  1  response present
- rsp_ready  input  1  processor accepts response
- rsp_rdata  output  32  load data; 0 for stores and errors
- rsp_err  output  1  address error on this response

Behaviour:
Reset:
- While reset=0: state IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
- RAM contents are not reset.
- req_ready rises on the first ref_clk edge after reset deasserts.

State machine:
- States are IDLE, WAIT, RESP.
- All outputs are registered.
- req_ready=1 only in IDLE.
- IDLE: on an edge with req_valid&&req_ready, latch we/addr/wdata/be and drop req_ready. Go to WAIT with counter=WAIT_STATES-1, or go to RESP if WAIT_STATES=0.
- WAIT: decrement the counter each edge; at 0, go to RESP.
- Entry into RESP (the commit edge):
  - Evaluate the error condition.
  - Perform the write or sample the read data from RAM.
  - Raise rsp_valid.
- Latency: rsp_valid is high exactly WAIT_STATES+1 edges after the accept edge.
- RESP: hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1. On the handshake edge, drop rsp_valid, clear rsp_rdata/rsp_err, go to IDLE, and raise req_ready.
- Throughput: one transaction per WAIT_STATES+2 cycles minimum.
- A request is never accepted in the same cycle a response completes.

Address rules:
- Word index = req_addr[ADDR_W+1:2].
- Error if req_addr[1:0]!=0, or if any bit of req_addr[31:ADDR_W+2] is set.
- On error: no RAM write, rsp_rdata=0, rsp_err=1.

Stores:
- Only bytes with req_be[i]=1 are written.
- be=4'b0000 is a legal no-op store with rsp_err=0.
- Store responses carry rsp_rdata=0.

Loads:
- be is ignored; the full word is returned.

Hazards and reset mid-operation:
- Read-after-write to the same address in consecutive transactions returns the new data; the RAM write completes at the commit edge, well before the next read.
- Reset asserted in WAIT: transaction abandoned, no write committed.
- Reset asserted in RESP: the write is already committed; the response is lost.
- req_valid or inputs changing while req_ready=0 are ignored.

Decomposition:
- Package mips_mem_pkg:
  - state enum (IDLE, WAIT, RESP)
  - WORD_BYTES=4
  - DATA_W=32
  - BE_W=4
  - error-condition helper function
- Sub-module dmem_array:
  - 2**ADDR_W x 32 RAM
  - synchronous byte-enabled write
  - registered read
  - enables driven only at the commit edge

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release → req_ready=1 one edge later; rsp_valid=0 and rsp_err=0 throughout.
- Store/load round trip, WAIT_STATES=2: store 0xDEADBEEF to 0x10 with be=4'hF → rsp_valid exactly 3 edges after accept, rsp_err=0; then load 0x10 → rsp_rdata=0xDEADBEEF.
- Byte enables: store 0x11223344 to 0x20 (be=F), then 0xAABBCCDD with be=4'b0101 → load 0x20 returns 0x11BB33DD.
- Errors, each expecting rsp_err=1 and rsp_rdata=0:
  - load 0x13 (misaligned)
  - store to 0x400 with ADDR_W=8 (out of range), after which a load of 0x0 is unchanged.
- Response backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid/rsp_rdata stable, req_ready=0; on rsp_ready=1, req_ready=1 the next edge.
- Reset mid-operation: accept store 0xCAFEF00D to 0x40, assert reset in WAIT, release → load 0x40 ≠ 0xCAFEF00D (prior value preserved); with WAIT_STATES=0, rsp_valid 1 edge after accept.
